// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast struct, tag widths, unit indices, pointer helper.
package cdb_arbiter_pkg;

  localparam int NUM_FU    = 4;
  localparam int ROB_IDX_W = 5;
  localparam int PRF_IDX_W = 6;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MDU = 2'd1,
    FU_LSU = 2'd2,
    FU_JMP = 2'd3
  } fu_idx_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRF_IDX_W-1:0] pd;
    logic                 rd_we;
    logic [DATA_W-1:0]    data;
  } cdb_t;

  // Round-robin successor: the slot after the winner becomes highest priority.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_core.sv
// Combinational rotate/priority-encode: first set request at or after ptr, wrapping.
module rr_arb_core #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_onehot_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] k;
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_o          = 1'b0;
    k              = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o             = 1'b1;
        grant_idx_o       = k;
        grant_onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a registered broadcast stage.
// Define CDB_ARB_PERF_EN to add grant/conflict/wait performance counters.
module cdb_arbiter #(
  parameter int NUM_REQ   = cdb_arbiter_pkg::NUM_FU,
  parameter int ROB_IDX_W = cdb_arbiter_pkg::ROB_IDX_W,
  parameter int PRF_IDX_W = cdb_arbiter_pkg::PRF_IDX_W,
  parameter int DATA_W    = cdb_arbiter_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_pd,
  input  logic [NUM_REQ-1:0]             req_rd_we,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
  output logic [PRF_IDX_W-1:0]           cdb_pd,
  output logic                           cdb_rd_we,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [$clog2(NUM_REQ)-1:0]     cdb_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]          perf_grant_cnt,
  output logic [31:0]                    perf_conflict_cnt,
  output logic [NUM_REQ*8-1:0]           perf_max_wait
`endif
);

  import cdb_arbiter_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] rob_arr;
  logic [NUM_REQ-1:0][PRF_IDX_W-1:0] pd_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0]    data_arr;

  assign rob_arr  = req_rob_idx;
  assign pd_arr   = req_pd;
  assign data_arr = req_data;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_rob_q, cdb_rob_d;
  logic [PRF_IDX_W-1:0] cdb_pd_q, cdb_pd_d;
  logic                 cdb_we_q, cdb_we_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic [PTR_W-1:0]     cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic               grant;

  rr_arb_core #(.N(NUM_REQ), .IW(PTR_W)) u_core (
    .req_i          (req_valid),
    .ptr_i          (rr_ptr_q),
    .grant_onehot_o (arb_onehot),
    .grant_idx_o    (arb_idx),
    .any_o          (arb_any)
  );

  // rdy is derived from the valid vector but never feeds back into it.
  always_comb begin
    grant       = arb_any & ~flush & ~rst;
    req_rdy     = grant ? arb_onehot : '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant;
    cdb_rob_d   = cdb_rob_q;
    cdb_pd_d    = cdb_pd_q;
    cdb_we_d    = cdb_we_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant) begin
      rr_ptr_d   = PTR_W'(rr_next(32'(arb_idx), NUM_REQ));
      cdb_rob_d  = rob_arr[arb_idx];
      cdb_pd_d   = pd_arr[arb_idx];
      cdb_we_d   = req_rd_we[arb_idx];
      cdb_data_d = data_arr[arb_idx];
      cdb_src_d  = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_pd_q    <= '0;
      cdb_we_q    <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_pd_q    <= cdb_pd_d;
      cdb_we_q    <= cdb_we_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_rob_q;
  assign cdb_pd      = cdb_pd_q;
  assign cdb_rd_we   = cdb_we_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_src     = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q;
  logic [NUM_REQ-1:0][7:0]  wait_q, max_wait_q;
  logic [31:0]              conflict_q;
  logic                     multi_req;

  assign multi_req = ($countones(req_valid) >= 2);

  // wait_q counts stalled cycles since valid rose; it is folded into the max on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      wait_q      <= '0;
      max_wait_q  <= '0;
      conflict_q  <= '0;
    end else if (!flush) begin
      if (multi_req && conflict_q != '1) conflict_q <= conflict_q + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_rdy[i]) begin
          if (grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
          if (wait_q[i] > max_wait_q[i]) max_wait_q[i] <= wait_q[i];
          wait_q[i] <= '0;
        end else if (req_valid[i]) begin
          if (wait_q[i] != '1) wait_q[i] <= wait_q[i] + 8'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

  assign perf_grant_cnt    = grant_cnt_q;
  assign perf_conflict_cnt = conflict_q;
  assign perf_max_wait     = max_wait_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench: driver predicts grants from the round-robin rule, monitor checks the CDB.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_rdy;
  logic [19:0] req_rob_idx = '0;
  logic [23:0] req_pd = '0;
  logic [3:0]  req_rd_we = '0;
  logic [127:0] req_data = '0;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic [5:0]  cdb_pd;
  logic        cdb_rd_we;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rdy(req_rdy),
    .req_rob_idx(req_rob_idx), .req_pd(req_pd), .req_rd_we(req_rd_we),
    .req_data(req_data), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd), .cdb_rd_we(cdb_rd_we),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  typedef struct packed {
    cdb_t       c;
    logic [1:0] src;
    logic       full;   // payload must be checked even with valid=0 (post-reset zeros)
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_bad = 0;
  bit   done = 0;

  // Per-unit pending request held until granted.
  bit   [3:0]  pv = '0;
  logic [4:0]  prob[4];
  logic [5:0]  ppd[4];
  logic        pwe[4];
  logic [31:0] pdata[4];
  int          ptr = 0;

  function automatic int pick(input bit [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic set_req(input int i, input int rob, input int pd, input bit we, input logic [31:0] d);
    pv[i] = 1'b1; prob[i] = 5'(rob); ppd[i] = 6'(pd); pwe[i] = we; pdata[i] = d;
  endtask

  task automatic cyc(input bit r, input bit f);
    int g;
    logic [3:0] er;
    exp_t e;
    @(negedge clk);
    rst = r; flush = f; req_valid = pv;
    for (int i = 0; i < 4; i++) begin
      req_rob_idx[i*5 +: 5] = prob[i];
      req_pd[i*6 +: 6]      = ppd[i];
      req_rd_we[i]          = pwe[i];
      req_data[i*32 +: 32]  = pdata[i];
    end
    #1;
    g  = (r || f) ? -1 : pick(pv, ptr);
    er = (g >= 0) ? 4'(1 << g) : 4'b0000;
    n_vec++;
    if (req_rdy !== er) begin
      n_bad++;
      $display("FAIL rdy t=%0t: got %b want %b (valid %b ptr %0d rst %0b flush %0b)", $time, req_rdy, er, pv, ptr, r, f);
    end
    e = '0;
    if (g >= 0) begin
      e.c.valid = 1'b1; e.c.rob_idx = prob[g]; e.c.pd = ppd[g];
      e.c.rd_we = pwe[g]; e.c.data = pdata[g]; e.src = 2'(g);
      pv[g] = 1'b0;
      ptr = (g + 1) % 4;
    end
    if (r) begin
      e.full = 1'b1;
      ptr = 0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per registered cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      n_vec++;
      if (cdb_valid !== e.c.valid) begin
        n_bad++;
        $display("FAIL cdb_valid t=%0t: got %b want %b", $time, cdb_valid, e.c.valid);
      end else if ((e.c.valid || e.full) &&
                   ({cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_data, cdb_src} !==
                    {e.c.rob_idx, e.c.pd, e.c.rd_we, e.c.data, e.src})) begin
        n_bad++;
        $display("FAIL cdb_payload t=%0t: got rob=%0d pd=%0d we=%b data=%h src=%0d want rob=%0d pd=%0d we=%b data=%h src=%0d",
                 $time, cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_data, cdb_src,
                 e.c.rob_idx, e.c.pd, e.c.rd_we, e.c.data, e.src);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      prob[i] = '0; ppd[i] = '0; pwe[i] = 1'b0; pdata[i] = '0;
    end
    // Reset then idle.
    cyc(1, 0); cyc(1, 0);
    repeat (10) cyc(0, 0);
    // Single persistent ALU requester: back-to-back broadcasts.
    for (int k = 0; k < 3; k++) begin
      set_req(0, 3 + k, 10 + k, 1'b1, 32'h11 * (k + 1));
      cyc(0, 0);
    end
    // All four continuously from ptr 0, then drain in pointer order.
    cyc(1, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++)
        if (!pv[i]) set_req(i, 8 + 4*k + i, 20 + i, i[0], 32'hA000_0000 + 32'(16*k + i));
      cyc(0, 0);
    end
    repeat (3) cyc(0, 0);
    // MDU alone moves ptr to 2, then MDU+JMP: JMP first, then MDU.
    set_req(1, 1, 1, 1'b1, 32'h0000_0101); cyc(0, 0);
    set_req(1, 2, 2, 1'b1, 32'h0000_0202);
    set_req(3, 3, 3, 1'b0, 32'h0000_0303);
    cyc(0, 0); cyc(0, 0);
    // LSU granted, then flush with all valid; ptr must stay at 3.
    set_req(2, 7, 7, 1'b1, 32'hCAFE_0007); cyc(0, 0);
    for (int i = 0; i < 4; i++) set_req(i, 16 + i, 30 + i, 1'b1, 32'hF000_0000 + 32'(i));
    cyc(0, 1);
    cyc(0, 0);
    // ALU granted, then reset while ALU still requesting.
    cyc(0, 0);
    set_req(0, 31, 63, 1'b1, 32'hDEAD_BEEF);
    cyc(1, 0);
    cyc(0, 0);
    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        if (!pv[i] && $urandom_range(1, 0) == 1)
          set_req(i, int'($urandom_range(31, 0)), int'($urandom_range(63, 0)),
                  1'($urandom_range(1, 0)), $urandom);
      cyc($urandom_range(99, 0) == 0, $urandom_range(99, 0) < 6);
    end
    repeat (6) cyc(0, 0);
    done = 1;
    @(posedge clk); @(posedge clk); #4;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional units that decode dispatches into: ALU, MDU, LSU and JMP.
- Each unit presents a completed result with a valid/rdy handshake.
- The arbiter grants one unit per cycle using round-robin priority and registers the winner onto the CDB, which broadcasts to the ROB, the reservation stations and the PRF.
- A flush input kills in-flight broadcasts on a mispredict.

Parameters:
- NUM_REQ, 4, number of requesting units; index 0=ALU, 1=MDU, 2=LSU, 3=JMP.
- ROB_IDX_W, 5, ROB tag width.
- PRF_IDX_W, 6, physical destination register tag width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-unit result valid
- req_rdy  out  NUM_REQ  per-unit grant; the handshake completes when valid&rdy
- req_rob_idx  in  NUM_REQ*ROB_IDX_W  packed ROB tags; unit i occupies bits [i*ROB_IDX_W +: ROB_IDX_W]
- req_pd  in  NUM_REQ*PRF_IDX_W  packed physical destination tags
- req_rd_we  in  NUM_REQ  result writes a register (0 for store/branch without rd)
- req_data  in  NUM_REQ*DATA_W  packed results
- flush  in  1  pipeline flush
- cdb_valid  out  1  broadcast valid
- cdb_rob_idx  out  ROB_IDX_W  broadcast ROB tag
- cdb_pd  out  PRF_IDX_W  broadcast physical tag
- cdb_rd_we  out  1  broadcast register write enable
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  $clog2(NUM_REQ)  index of the granted unit

Behaviour:
- Reset values:
  - rst=1 at posedge clears cdb_valid, cdb_rob_idx, cdb_pd, cdb_rd_we, cdb_data and cdb_src to 0.
  - Round-robin pointer rr_ptr resets to 0.
  - req_rdy is 0 while rst=1.
- Grant (combinational, same cycle):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner; req_rdy is one-hot on the winner, or all-zero if no valid.
  - req_rdy never depends on a unit's own valid in a way that creates a loop; units must hold valid and payload stable until rdy.
- Pointer update:
  - On a grant at index g, rr_ptr <= (g+1) mod NUM_REQ on the next edge.
  - With no grant, rr_ptr holds.
- Output register, latency 1:
  - On a grant, at the next edge cdb_valid<=1 and the payload and cdb_src take the winner's fields.
  - With no grant, cdb_valid<=0; payload regs hold their old value (don't-care).
- The CDB has no back-pressure; a broadcast is always consumed in its valid cycle.
- Flush:
  - While flush=1, req_rdy=0 (no grants) and cdb_valid<=0 at the next edge.
  - rr_ptr holds during flush.
  - A broadcast already registered when flush rises is still visible that cycle; downstream discards it by flush.
- Boundaries:
  - All NUM_REQ valid for NUM_REQ cycles: each unit is granted exactly once, in pointer order.
  - A single persistent requester is granted every cycle, giving back-to-back cdb_valid.
  - Max wait for any held-valid unit is NUM_REQ-1 cycles.
  - rst asserted mid-stream has priority over everything: the in-flight broadcast is dropped.
  - rst and flush together behave as rst.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- With the macro defined, add outputs:
  - perf_grant_cnt[NUM_REQ*32]: per-unit grant counters.
  - perf_conflict_cnt[32]: cycles with ≥2 valid requesters.
  - perf_max_wait[NUM_REQ*8]: per-unit longest wait from valid rise to rdy, saturating at 255.
- All perf outputs reset to 0, increment on the edge after the event, and saturate rather than wrap.
- Counters do not increment while flush=1.
- Without the macro: no perf ports and no perf logic; arbitration behaviour is identical either way.

Decomposition:
- rv32i_types gains:
  - cdb_t struct {valid, rob_idx, pd, rd_we, data}.
  - Constants ROB_IDX_W and PRF_IDX_W.
  - Unit index enum fu_idx_t {FU_ALU, FU_MDU, FU_LSU, FU_JMP}.
- One sub-module: rr_arb_core, a pure combinational rotate/priority-encode taking (req, ptr) and returning (grant_onehot, grant_idx, any). It is reusable by the reservation-station issue select.

Test Plan:
- Reset release, no valids -> cdb_valid=0 and req_rdy=0000 for 10 cycles; rr_ptr=0.
- Only ALU valid for 3 cycles with rob_idx 3,4,5 and data 0x11,0x22,0x33 -> req_rdy[0]=1 each cycle; cdb_valid=1 one cycle later with matching tags/data and cdb_src=0 for 3 consecutive cycles.
- All 4 valid continuously from rr_ptr=0 -> grant order 0,1,2,3,0; cdb_src sequence 0,1,2,3,0.
- MDU(1) and JMP(3) valid with rr_ptr=2 -> JMP is granted first, then MDU; cdb_src 3 then 1.
- LSU granted in cycle N, flush=1 in cycle N+1 with all units valid -> cdb_valid=1 in N+1 (LSU), 0 in N+2; no rdy during flush; rr_ptr=3 preserved.
- rst pulsed while ALU is granted -> cdb_valid=0 the cycle after rst; rr_ptr=0; with CDB_ARB_PERF_EN, all counters read 0.
